// File: rtl/tff_updown_counter.sv
// Modulo-MODULUS up/down counter built from per-bit toggle stages with parallel load.
// Define GRAY_OUT_EN to add a registered Gray-coded copy of the count (q_gray).
module tff_updown_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc,
   output logic             wrap,
`ifdef GRAY_OUT_EN
   output logic [WIDTH-1:0] q_gray,
`endif
   output logic             load_err
);

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   generate
      if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_params
         $error("tff_updown_counter: illegal WIDTH/MODULUS combination");
      end
`ifdef GRAY_OUT_EN
      if ((MODULUS & (MODULUS - 1)) != 0) begin : g_bad_gray
         $error("tff_updown_counter: q_gray requires a power-of-two MODULUS");
      end
`endif
   endgenerate

   logic [WIDTH-1:0] t_up;
   logic [WIDTH-1:0] t_down;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;
   logic             load_err_next;

   // Toggle masks: bit i flips when all lower bits are 1 (up) or all 0 (down)
   always_comb begin
      t_up      = '0;
      t_down    = '0;
      t_up[0]   = 1'b1;
      t_down[0] = 1'b1;
      for (int i = 1; i < int'(WIDTH); i++) begin
         t_up[i]   = t_up[i-1] & q[i-1];
         t_down[i] = t_down[i-1] & ~q[i-1];
      end
   end

   always_comb begin
      q_next        = q;
      wrap_next     = 1'b0;
      load_err_next = 1'b0;
      if (en) begin
         case (mode)
            MODE_UP: begin
               if (q == MAX_Q) begin
                  q_next    = '0;
                  wrap_next = 1'b1;
               end else begin
                  q_next = q ^ t_up;
               end
            end
            MODE_DOWN: begin
               if (q == '0) begin
                  q_next    = MAX_Q;
                  wrap_next = 1'b1;
               end else begin
                  q_next = q ^ t_down;
               end
            end
            MODE_LOAD: begin
               if (32'(load_val) < MODULUS) begin
                  q_next = load_val;
               end else begin
                  q_next        = MAX_Q;
                  load_err_next = 1'b1;
               end
            end
            MODE_HOLD: ;
            default: ;
         endcase
      end
   end

   assign tc = en & (((mode == MODE_UP) & (q == MAX_Q)) | ((mode == MODE_DOWN) & (q == '0)));

   always_ff @(posedge clk) begin
      if (rst) begin
         q        <= '0;
         qbar     <= '1;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         q        <= q_next;
         qbar     <= ~q_next;
         wrap     <= wrap_next;
         load_err <= load_err_next;
      end
   end

`ifdef GRAY_OUT_EN
   always_ff @(posedge clk) begin
      if (rst) q_gray <= '0;
      else     q_gray <= (q_next >> 1) ^ q_next;
   end
`endif

endmodule

// File: tb/tb_tff_updown_counter.sv
// Randomised and directed check of tff_updown_counter (WIDTH=4, MODULUS=10)
// against an arithmetic reference model.
module tb_tff_updown_counter;
   localparam int unsigned WIDTH   = 4;
   localparam int unsigned MODULUS = 10;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en  = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] q, qbar;
   logic             tc, wrap, load_err;
`ifdef GRAY_OUT_EN
   logic [WIDTH-1:0] q_gray;
`endif

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   int m_q    = 0;
   int m_wrap = 0;
   int m_err  = 0;

   tff_updown_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .load_val (load_val),
      .q        (q),
      .qbar     (qbar),
      .tc       (tc),
      .wrap     (wrap),
`ifdef GRAY_OUT_EN
      .q_gray   (q_gray),
`endif
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: plain modular arithmetic on the count
   always @(posedge clk) begin
      m_wrap = 0;
      m_err  = 0;
      if (rst) begin
         m_q = 0;
      end else if (en) begin
         case (mode)
            2'd1: begin
               m_q = (m_q + 1) % MODULUS;
               if (m_q == 0) m_wrap = 1;
            end
            2'd2: begin
               if (m_q == 0) m_wrap = 1;
               m_q = (m_q + MODULUS - 1) % MODULUS;
            end
            2'd3: begin
               if (int'(load_val) < MODULUS) m_q = int'(load_val);
               else begin
                  m_q   = MODULUS - 1;
                  m_err = 1;
               end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         int exp_tc;
         exp_tc = (en && ((mode == 2'd1 && m_q == MODULUS - 1) || (mode == 2'd2 && m_q == 0))) ? 1 : 0;
         chk("model_q", int'(q), m_q);
         chk("model_qbar", int'(qbar), int'(~WIDTH'(m_q)) & ((1 << WIDTH) - 1));
         chk("model_wrap", int'(wrap), m_wrap);
         chk("model_load_err", int'(load_err), m_err);
         chk("model_tc", int'(tc), exp_tc);
      end
   end

   // Apply inputs just after a falling edge; return just after the next falling edge
   task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic [WIDTH-1:0] lv);
      rst = r; en = e; mode = m; load_val = lv;
      @(negedge clk);
      #1;
   endtask

   initial begin
      int exp_up[12];
      int exp_dn[5];
      exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      exp_dn = '{2, 1, 0, 9, 8};

      @(negedge clk);
      #1;
      check_en = 1'b1;
      chk("reset_q", int'(q), 0);
      chk("reset_qbar", int'(qbar), 15);
      chk("reset_wrap", int'(wrap), 0);
      chk("reset_load_err", int'(load_err), 0);

      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b1, 2'd1, '0);
         chk("up_q", int'(q), exp_up[i]);
         chk("up_wrap", int'(wrap), (i == 9) ? 1 : 0);
         if (i == 8) chk("up_tc_at_9", int'(tc), 1);
      end

      drive(1'b0, 1'b1, 2'd3, 4'd3);
      chk("load3_q", int'(q), 3);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 2'd2, '0);
         chk("down_q", int'(q), exp_dn[i]);
         chk("down_wrap", int'(wrap), (i == 3) ? 1 : 0);
         if (i == 2) chk("down_tc_at_0", int'(tc), 1);
      end

      drive(1'b0, 1'b1, 2'd3, 4'd12);
      chk("badload_q", int'(q), 9);
      chk("badload_err", int'(load_err), 1);
      chk("badload_wrap", int'(wrap), 0);
      drive(1'b0, 1'b1, 2'd0, '0);
      chk("hold_q", int'(q), 9);
      chk("hold_err", int'(load_err), 0);

      en = 1'b0; mode = 2'd1;
      #1;
      chk("dis_tc", int'(tc), 0);
      drive(1'b0, 1'b0, 2'd1, '0);
      chk("dis_q", int'(q), 9);
      chk("dis_wrap", int'(wrap), 0);
      drive(1'b0, 1'b1, 2'd2, '0);
      chk("switch_q", int'(q), 8);
      chk("switch_wrap", int'(wrap), 0);

      drive(1'b0, 1'b1, 2'd3, 4'd5);
      drive(1'b0, 1'b1, 2'd1, '0);
      chk("pre_rst_q", int'(q), 6);
      drive(1'b1, 1'b1, 2'd1, '0);
      chk("midrst_q", int'(q), 0);
      chk("midrst_qbar", int'(qbar), 15);
      chk("midrst_wrap", int'(wrap), 0);
      drive(1'b0, 1'b1, 2'd1, '0);
      chk("post_rst_q", int'(q), 1);

      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
               2'($urandom_range(0, 3)),
               WIDTH'($urandom_range(0, 15)));
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
